// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - scancode byte stream in, key events and held mask out
interface ps2_key_decoder_if #(
    parameter int NUM_KEYS = 8,
    parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
    logic [7:0]          ps2_key_data;
    logic                ps2_key_pressed;
    logic                clear_all;
    logic [NUM_KEYS-1:0] key_held;
    logic                event_valid;
    logic                event_release;
    logic                event_repeat;
    logic [IDX_W-1:0]    event_index;
    logic                proto_err;

    modport master (
        output ps2_key_data, ps2_key_pressed, clear_all,
        input  key_held, event_valid, event_release, event_repeat, event_index, proto_err
    );

    modport slave (
        input  ps2_key_data, ps2_key_pressed, clear_all,
        output key_held, event_valid, event_release, event_repeat, event_index, proto_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 scancode decoder with table lookup and held-key tracking
module ps2_key_decoder #(
    parameter int                  NUM_KEYS       = 8,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES    = {8'h29, 8'h6C, 8'h69, 8'h14, 8'h74, 8'h6B, 8'h72, 8'h75},
    parameter logic [NUM_KEYS-1:0] KEY_EXT        = 8'b0111_1111,
    parameter bit                  REPORT_REPEAT  = 1'b0,
    parameter int                  TIMEOUT_CYCLES = 150000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    ps2_key_decoder_if.slave   bus
);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t              state, state_nx;
    logic [2:0]          skip, skip_nx;
    logic [CW-1:0]       cnt, cnt_nx, cnt_inc;
    logic [NUM_KEYS-1:0] held, held_nx;
    logic                ev_valid, ev_valid_nx;
    logic                ev_rel, ev_rel_nx;
    logic                ev_rep, ev_rep_nx;
    logic [IDX_W-1:0]    ev_idx, ev_idx_nx;
    logic                perr, perr_nx;

    logic                ext_mode;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                do_make, do_brk;
    logic [7:0]          b;

    assign b        = bus.ps2_key_data;
    assign ext_mode = (state == S_EXT) || (state == S_EXT_BRK);
    assign cnt_inc  = cnt + CW'(1);

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == b && KEY_EXT[i] == ext_mode) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        skip_nx     = skip;
        cnt_nx      = cnt;
        held_nx     = held;
        ev_valid_nx = 1'b0;
        ev_rel_nx   = 1'b0;
        ev_rep_nx   = 1'b0;
        ev_idx_nx   = '0;
        perr_nx     = 1'b0;
        do_make     = 1'b0;
        do_brk      = 1'b0;

        if (bus.clear_all) begin
            held_nx  = '0;
            state_nx = S_IDLE;
            skip_nx  = '0;
            cnt_nx   = '0;
        end else if (bus.ps2_key_pressed) begin
            cnt_nx = '0;
            if (state != S_PAUSE && b == 8'hAA) begin
                held_nx  = '0;
                state_nx = S_IDLE;
            end else if (state != S_PAUSE && (b == 8'h00 || b == 8'hFF)) begin
                held_nx  = '0;
                perr_nx  = 1'b1;
                state_nx = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (b == 8'hE0)      state_nx = S_EXT;
                        else if (b == 8'hF0) state_nx = S_BRK;
                        else if (b == 8'hE1) begin
                            state_nx = S_PAUSE;
                            skip_nx  = 3'd7;
                        end else if (b != 8'hFA && b != 8'hEE) do_make = 1'b1;
                    end
                    S_EXT: begin
                        if (b == 8'hF0)      state_nx = S_EXT_BRK;
                        else if (b != 8'hE0) begin
                            state_nx = S_IDLE;
                            do_make  = (b != 8'h12) && (b != 8'h59);
                        end
                    end
                    S_BRK: begin
                        if (b != 8'hF0) begin
                            state_nx = S_IDLE;
                            do_brk   = 1'b1;
                        end
                    end
                    S_EXT_BRK: begin
                        if (b != 8'hF0) begin
                            state_nx = S_IDLE;
                            do_brk   = (b != 8'h12) && (b != 8'h59);
                        end
                    end
                    S_PAUSE: begin
                        skip_nx = skip - 3'd1;
                        if (skip == 3'd1) state_nx = S_IDLE;
                    end
                    default: state_nx = S_IDLE;
                endcase
            end

            if (do_make && hit) begin
                if (!held[hit_idx]) begin
                    held_nx[hit_idx] = 1'b1;
                    ev_valid_nx      = 1'b1;
                    ev_idx_nx        = hit_idx;
                end else if (REPORT_REPEAT) begin
                    ev_valid_nx = 1'b1;
                    ev_rep_nx   = 1'b1;
                    ev_idx_nx   = hit_idx;
                end
            end
            if (do_brk && hit && held[hit_idx]) begin
                held_nx[hit_idx] = 1'b0;
                ev_valid_nx      = 1'b1;
                ev_rel_nx        = 1'b1;
                ev_idx_nx        = hit_idx;
            end
        end else if (state != S_IDLE) begin
            // A stalled prefix is abandoned; held keys survive because their breaks may still come.
            if (cnt_inc == TO_VAL) begin
                state_nx = S_IDLE;
                skip_nx  = '0;
                cnt_nx   = '0;
                perr_nx  = 1'b1;
            end else begin
                cnt_nx = cnt_inc;
            end
        end else begin
            cnt_nx = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            skip     <= '0;
            cnt      <= '0;
            held     <= '0;
            ev_valid <= 1'b0;
            ev_rel   <= 1'b0;
            ev_rep   <= 1'b0;
            ev_idx   <= '0;
            perr     <= 1'b0;
        end else begin
            state    <= state_nx;
            skip     <= skip_nx;
            cnt      <= cnt_nx;
            held     <= held_nx;
            ev_valid <= ev_valid_nx;
            ev_rel   <= ev_rel_nx;
            ev_rep   <= ev_rep_nx;
            ev_idx   <= ev_idx_nx;
            perr     <= perr_nx;
        end
    end

    assign bus.key_held      = held;
    assign bus.event_valid   = ev_valid;
    assign bus.event_release = ev_rel;
    assign bus.event_repeat  = ev_rep;
    assign bus.event_index   = ev_idx;
    assign bus.proto_err     = perr;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       pressed = 1'b0;
    logic       clr = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ps2_key_decoder_if #(.NUM_KEYS(8)) bus0 ();
    ps2_key_decoder_if #(.NUM_KEYS(8)) bus1 ();

    assign bus0.ps2_key_data = data;
    assign bus0.ps2_key_pressed = pressed;
    assign bus0.clear_all = clr;
    assign bus1.ps2_key_data = data;
    assign bus1.ps2_key_pressed = pressed;
    assign bus1.clear_all = clr;

    ps2_key_decoder #(.REPORT_REPEAT(1'b0), .TIMEOUT_CYCLES(TO)) dut0 (
        .CLOCK_50(clk), .reset(rst), .bus(bus0));
    ps2_key_decoder #(.REPORT_REPEAT(1'b1), .TIMEOUT_CYCLES(TO)) dut1 (
        .CLOCK_50(clk), .reset(rst), .bus(bus1));

    function automatic logic [31:0] pk(input logic v, input logic rl, input logic rp,
                                       input logic [2:0] ix, input logic pe, input logic [7:0] hd);
        return {17'd0, v, rl, rp, ix, pe, hd};
    endfunction

    function automatic logic [31:0] act0();
        return pk(bus0.event_valid, bus0.event_release, bus0.event_repeat, bus0.event_index, bus0.proto_err, bus0.key_held);
    endfunction

    function automatic logic [31:0] act1();
        return pk(bus1.event_valid, bus1.event_release, bus1.event_repeat, bus1.event_index, bus1.proto_err, bus1.key_held);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b, input bit c);
        @(negedge clk);
        data = b;
        pressed = 1'b1;
        clr = c;
        @(negedge clk);
        pressed = 1'b0;
        clr = 1'b0;
        data = 8'h00;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         c;
        bit         ev;
        bit         ev1;
        bit         rel;
        bit         rep1;
        logic [2:0] idx;
        bit         perr;
        logic [7:0] held;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input bit c, input bit ev, input bit ev1, input bit rel,
                                input bit rep1, input logic [2:0] idx, input bit perr, input logic [7:0] held);
        vec_t v;
        v.d = d; v.c = c; v.ev = ev; v.ev1 = ev1; v.rel = rel; v.rep1 = rep1;
        v.idx = idx; v.perr = perr; v.held = held;
        return v;
    endfunction

    function automatic vec_t nb(input logic [7:0] d, input logic [7:0] held);
        return mk(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, held);
    endfunction

    // Reference model: table of (code, ext) pairs plus the bytes of the unfinished sequence.
    logic [7:0] tbl_code[8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h69, 8'h6C, 8'h29};
    bit         tbl_ext[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] m_pend[$];
    int         m_pause;
    bit         m_held[8];

    function automatic int find(input logic [7:0] b, input bit x);
        for (int i = 0; i < 8; i++) if (tbl_code[i] == b && tbl_ext[i] == x) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_held_vec();
        logic [7:0] h;
        for (int i = 0; i < 8; i++) h[i] = m_held[i];
        return h;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_held[i] = 1'b0;
        m_pend.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ev, output bit rel, output bit rep,
                              output logic [2:0] idx, output bit perr);
        bit has_e0, has_f0;
        int k;
        ev = 0; rel = 0; rep = 0; idx = 3'd0; perr = 0;
        if (m_pause > 0) begin m_pause--; return; end
        if (b == 8'hAA) begin m_clear(); return; end
        if (b == 8'h00 || b == 8'hFF) begin m_clear(); perr = 1; return; end
        has_e0 = 0; has_f0 = 0;
        foreach (m_pend[j]) begin
            if (m_pend[j] == 8'hE0) has_e0 = 1;
            if (m_pend[j] == 8'hF0) has_f0 = 1;
        end
        if (b == 8'hF0 || (b == 8'hE0 && !has_f0)) begin m_pend.push_back(b); return; end
        if (m_pend.size() == 0 && b == 8'hE1) begin m_pause = 7; return; end
        if (m_pend.size() == 0 && (b == 8'hFA || b == 8'hEE)) return;
        m_pend.delete();
        if (has_e0 && (b == 8'h12 || b == 8'h59)) return;
        k = find(b, has_e0);
        if (k < 0) return;
        idx = 3'(k);
        if (!has_f0) begin
            ev = 1;
            if (m_held[k]) rep = 1;
            m_held[k] = 1;
        end else if (m_held[k]) begin
            m_held[k] = 0;
            ev = 1;
            rel = 1;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 31);
        if (r < 10) return tbl_code[$urandom_range(0, 7)];
        if (r < 16) return 8'hE0;
        if (r < 20) return 8'hF0;
        if (r == 20) return 8'hE1;
        if (r == 21) return 8'hAA;
        if (r == 22) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        if (r == 23) return ($urandom_range(0, 1) != 0) ? 8'hFA : 8'hEE;
        if (r == 24) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int found, pulses;
        logic [7:0] b;
        bit c, ev, rel, rep, perr;
        logic [2:0] idx;

        // press/release up
        vecs.push_back(nb(8'hE0, 8'h00));
        vecs.push_back(mk(8'h75, 0, 1, 1, 0, 0, 3'd0, 0, 8'h01));
        vecs.push_back(nb(8'hE0, 8'h01));
        vecs.push_back(nb(8'hF0, 8'h01));
        vecs.push_back(mk(8'h75, 0, 1, 1, 1, 0, 3'd0, 0, 8'h00));
        // simultaneous keys and ext mismatch
        vecs.push_back(nb(8'hE0, 8'h00));
        vecs.push_back(mk(8'h6B, 0, 1, 1, 0, 0, 3'd2, 0, 8'h04));
        vecs.push_back(nb(8'hE0, 8'h04));
        vecs.push_back(mk(8'h74, 0, 1, 1, 0, 0, 3'd3, 0, 8'h0C));
        vecs.push_back(mk(8'h29, 0, 1, 1, 0, 0, 3'd7, 0, 8'h8C));
        vecs.push_back(nb(8'hE0, 8'h8C));
        vecs.push_back(nb(8'h29, 8'h8C));
        // typematic repeat
        for (int r = 0; r < 3; r++) begin
            vecs.push_back(nb(8'hE0, (r == 0) ? 8'h8C : 8'h8E));
            if (r == 0) vecs.push_back(mk(8'h72, 0, 1, 1, 0, 0, 3'd1, 0, 8'h8E));
            else        vecs.push_back(mk(8'h72, 0, 0, 1, 0, 1, 3'd1, 0, 8'h8E));
        end
        // pause sequence, then right ctrl
        vecs.push_back(nb(8'hE1, 8'h8E)); vecs.push_back(nb(8'h14, 8'h8E));
        vecs.push_back(nb(8'h77, 8'h8E)); vecs.push_back(nb(8'hE1, 8'h8E));
        vecs.push_back(nb(8'hF0, 8'h8E)); vecs.push_back(nb(8'h14, 8'h8E));
        vecs.push_back(nb(8'hF0, 8'h8E)); vecs.push_back(nb(8'h77, 8'h8E));
        vecs.push_back(nb(8'hE0, 8'h8E));
        vecs.push_back(mk(8'h14, 0, 1, 1, 0, 0, 3'd4, 0, 8'h9E));
        // ack byte, fake shifts, repeated F0
        vecs.push_back(nb(8'hFA, 8'h9E));
        vecs.push_back(nb(8'hE0, 8'h9E)); vecs.push_back(nb(8'h12, 8'h9E));
        vecs.push_back(nb(8'hE0, 8'h9E)); vecs.push_back(nb(8'hF0, 8'h9E)); vecs.push_back(nb(8'h59, 8'h9E));
        vecs.push_back(nb(8'hE0, 8'h9E));
        vecs.push_back(mk(8'h75, 0, 1, 1, 0, 0, 3'd0, 0, 8'h9F));
        vecs.push_back(nb(8'hE0, 8'h9F)); vecs.push_back(nb(8'hF0, 8'h9F)); vecs.push_back(nb(8'hF0, 8'h9F));
        vecs.push_back(mk(8'h75, 0, 1, 1, 1, 0, 3'd0, 0, 8'h9E));
        vecs.push_back(nb(8'hE0, 8'h9E));
        vecs.push_back(mk(8'h75, 0, 1, 1, 0, 0, 3'd0, 0, 8'h9F));
        // self-test pass, clear_all coincident with a strobe
        vecs.push_back(nb(8'hAA, 8'h00));
        vecs.push_back(nb(8'hE0, 8'h00));
        vecs.push_back(mk(8'h75, 1, 0, 0, 0, 0, 3'd0, 0, 8'h00));
        vecs.push_back(nb(8'h75, 8'h00));
        vecs.push_back(mk(8'h29, 0, 1, 1, 0, 0, 3'd7, 0, 8'h80));
        // error bytes, mid-sequence and idle
        vecs.push_back(nb(8'hE0, 8'h80));
        vecs.push_back(mk(8'h00, 0, 0, 0, 0, 0, 3'd0, 1, 8'h00));
        vecs.push_back(nb(8'h75, 8'h00));
        vecs.push_back(nb(8'h6B, 8'h00));
        vecs.push_back(mk(8'hFF, 0, 0, 0, 0, 0, 3'd0, 1, 8'h00));

        repeat (3) @(negedge clk);
        chk("reset_dut0", act0(), 32'd0);
        chk("reset_dut1", act1(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_dut0", act0(), 32'd0);

        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].c);
            chk($sformatf("vec%0d_dut0", i), act0(),
                pk(vecs[i].ev, vecs[i].rel, 1'b0, vecs[i].ev ? vecs[i].idx : 3'd0, vecs[i].perr, vecs[i].held));
            chk($sformatf("vec%0d_dut1", i), act1(),
                pk(vecs[i].ev1, vecs[i].rel, vecs[i].rep1, vecs[i].ev1 ? vecs[i].idx : 3'd0, vecs[i].perr, vecs[i].held));
        end

        // stalled prefix
        send(8'h29, 1'b0);
        chk("to_setup", act0(), pk(1, 0, 0, 3'd7, 0, 8'h80));
        send(8'hE0, 1'b0);
        found = -1;
        for (int n = 1; n <= 4 * TO; n++) begin
            @(negedge clk);
            if (bus0.proto_err) begin found = n; break; end
        end
        chk("timeout_latency", 32'(found), 32'(TO));
        chk("timeout_held", {24'd0, bus0.key_held}, 32'h80);
        pulses = 0;
        for (int n = 0; n < 3 * TO; n++) begin
            @(negedge clk);
            if (bus0.proto_err || bus0.event_valid) pulses++;
        end
        chk("timeout_single_pulse", 32'(pulses), 32'd0);
        send(8'h75, 1'b0);
        chk("after_timeout_75", act0(), pk(0, 0, 0, 3'd0, 0, 8'h80));

        // reset in the middle of a break sequence
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_dut0", act0(), 32'd0);
        chk("async_reset_dut1", act1(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h75, 1'b0);
        chk("after_reset_75", act0(), 32'd0);

        // randomized traffic against the model
        m_clear();
        m_pause = 0;
        for (int t = 0; t < 400; t++) begin
            b = rand_byte();
            c = ($urandom_range(0, 24) == 0);
            send(b, c);
            if (c) begin
                m_clear();
                m_pause = 0;
                ev = 0; rel = 0; rep = 0; idx = 3'd0; perr = 0;
            end else begin
                model_byte(b, ev, rel, rep, idx, perr);
            end
            chk($sformatf("rand%0d_b%h_dut0", t, b), act0(),
                pk(ev && !rep, rel, 1'b0, (ev && !rep) ? idx : 3'd0, perr, m_held_vec()));
            chk($sformatf("rand%0d_b%h_dut1", t, b), act1(),
                pk(ev, rel, rep, ev ? idx : 3'd0, perr, m_held_vec()));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk($sformatf("rand%0d_idle", t), act0(), pk(0, 0, 0, 3'd0, 0, m_held_vec()));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Parametrised PS/2 set-2 scancode decoder. It replaces the fixed seven-key arrow/ctrl/end/home decoder. It sits between PS2_Controller (received byte plus strobe) and game control logic. It matches a configurable table of standard and E0-extended keys, tracks a held-key bitmask that supports simultaneous keys, and emits press, release and repeat events. It also handles the Pause sequence, keyboard self-test/error bytes, and stalled multi-byte sequences.

Parameters:
NUM_KEYS, 8, number of table entries (1..32).
KEY_CODES, {8'h29,8'h6C,8'h69,8'h14,8'h74,8'h6B,8'h72,8'h75}, packed 8*NUM_KEYS; entry i = bits [8i+7:8i] (0=up,1=down,2=left,3=right,4=ctrl,5=end,6=home,7=space).
KEY_EXT, 8'b0111_1111, bit i=1: entry i requires E0 prefix.
REPORT_REPEAT, 0, 1: typematic re-make of a held key emits an event with event_repeat=1.
TIMEOUT_CYCLES, 150000, cycles without a strobe before an unfinished prefix sequence is abandoned (3 ms at 50 MHz).

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_key_data  in  8  received byte from PS2_Controller
ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid only while it is high
clear_all  in  1  synchronous clear of held state
key_held  out  NUM_KEYS  bit i = entry i currently held
event_valid  out  1  one-cycle event pulse
event_release  out  1  qualifies event_valid: 1=release, 0=press/repeat
event_repeat  out  1  qualifies event_valid: typematic repeat
event_index  out  IDX_W  table index of event; IDX_W = max(1,$clog2(NUM_KEYS))
proto_err  out  1  one-cycle pulse on error byte or timeout

Behaviour:
- All outputs are registered. Reset (async assert, sync-safe deassert): state=IDLE, counters 0, all outputs 0.
- Bytes are consumed only on cycles with ps2_key_pressed=1. Event and proto_err pulses assert the cycle after the final byte's strobe (latency 1).
- Lookup: byte b with extended flag x matches entry i iff KEY_CODES[i]==b and KEY_EXT[i]==x. The lowest matching index wins. No match means no event; the state still returns to IDLE.
- States:
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> PAUSE, skip counter = 7
    - AA -> clear key_held, stay IDLE, no event
    - 00 or FF -> clear key_held, proto_err, stay IDLE
    - FA or EE -> ignored
    - any other byte -> make lookup with x=0, stay IDLE
  - EXT:
    - F0 -> EXT_BRK
    - E0 -> stay EXT
    - 12 or 59 (fake shift) -> IDLE, ignored
    - any other byte -> make lookup with x=1, then IDLE
  - BRK:
    - F0 -> stay BRK
    - any other byte -> break lookup with x=0, then IDLE
  - EXT_BRK:
    - F0 -> stay EXT_BRK
    - 12 or 59 -> IDLE, ignored
    - any other byte -> break lookup with x=1, then IDLE
  - PAUSE: every byte decrements the skip counter; return to IDLE after the 7th byte. No events are emitted.
- Make on entry i:
  - if key_held[i]=0: set it, emit event (release=0, repeat=0).
  - if key_held[i]=1: emit a repeat event only if REPORT_REPEAT=1; key_held is unchanged.
- Break on entry i:
  - if key_held[i]=1: clear it, emit event (release=1).
  - if key_held[i]=0: no event.
- Timeout: the counter resets on every strobe and counts only in non-IDLE states. When it reaches TIMEOUT_CYCLES: state -> IDLE, proto_err pulse, key_held untouched. Counter width is $clog2(TIMEOUT_CYCLES+1).
- clear_all: the next cycle gives key_held=0 and state=IDLE, with no release events. If a strobe arrives in the same cycle, clear_all wins and that byte is dropped.
- An error byte or AA arriving in any non-IDLE state (except PAUSE) is handled as in IDLE.
- At most one event per strobe. All remaining outputs are 0 between events.

Test Plan:
1. Strobe E0,75 -> key_held=8'h01, event_valid for 1 cycle with index=0, release=0. Then E0,F0,75 -> key_held=0, event index=0, release=1.
2. E0,6B then E0,74 (both held) -> key_held=8'h0C. Then 29 -> key_held=8'h8C, event index=7. Then E0,29 -> no event (ext mismatch).
3. REPORT_REPEAT=0: E0,72 sent three times -> one event. REPORT_REPEAT=1: same stimulus -> one press event, then two events with repeat=1, index=1.
4. E0 followed by 200000 idle cycles -> proto_err pulses exactly TIMEOUT_CYCLES cycles after the E0 strobe. Then 75 -> no event, key_held unchanged.
5. Pause sequence E1,14,77,E1,F0,14,F0,77 -> no events, no error. Then E0,14 -> key_held[4]=1.
6. Hold up and space, then AA -> key_held=0, no events. clear_all coincident with the 75 strobe of E0,75 -> byte dropped, key_held=0. Reset asserted mid-sequence after E0,F0 -> outputs 0 immediately, and 75 afterwards produces no event.
